// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle CPU: sequences FETCH, DECODE, execute, writeback.
// Optional macro MULTI_CYCLE_CTRL_TRAP_EN: unknown opcodes park in TRAP and raise illegal_op.
module multi_cycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
  output logic       illegal_op,
`endif
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  state_t state;

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          if (op == OP_LW || op == OP_SW) state <= S_MEMADR;
          else if (op == OP_RTYPE)        state <= S_EXEC;
          else if (op == OP_BEQ)          state <= S_BRANCH;
          else if (op == OP_J)            state <= S_JUMP;
          else if (op == OP_ADDI)         state <= S_ADDIEX;
          else begin
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
            state <= S_TRAP;
`else
            state <= S_FETCH;
`endif
          end
        end
        // IR is stable here, so op still identifies load versus store.
        S_MEMADR: state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        S_EXEC:   state <= S_ALUWB;
        S_ALUWB:  state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_JUMP:   state <= S_FETCH;
        S_ADDIEX: state <= S_ADDIWB;
        S_ADDIWB: state <= S_FETCH;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state register, so reset clears them at once;
  // only IRWrite/PCWrite in FETCH also look at mem_ready.
  always_comb begin
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
  end

`ifdef MULTI_CYCLE_CTRL_TRAP_EN
  assign illegal_op = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized bench for multi_cycle_control: per-instruction expected control timelines
// are built from the opcode and memory-wait counts, then compared cycle by cycle.
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;
  logic       IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state_dbg;
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
  logic       illegal_op;
`endif

  multi_cycle_control dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .state_dbg(state_dbg)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  localparam logic [5:0] RTYPE = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: one entry per clock cycle of expected control outputs and driven inputs.
  logic [15:0] exp_q[$];
  logic        mr_q[$];
  logic [5:0]  op_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // {IRWrite,PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  function automatic logic [15:0] outs();
    return {IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
  endfunction

  function automatic logic [15:0] v(input logic ir, pw, pwc, iord, mrd, mwr, m2r, rd, rw, sa,
                                    input logic [1:0] sb, aop, ps);
    return {ir, pw, pwc, iord, mrd, mwr, m2r, rd, rw, sa, sb, aop, ps};
  endfunction

  function automatic logic [5:0] rand_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rand_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [15:0] e, input logic mr, input logic [5:0] o);
    exp_q.push_back(e);
    mr_q.push_back(mr);
    op_q.push_back(o);
  endtask

  // Expected control timeline of one instruction, from FETCH to the cycle before the next FETCH.
  task automatic add_instr(input logic [5:0] o, input int fw, input int mw);
    logic [15:0] mem_addr;
    mem_addr = v(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
    for (int i = 0; i < fw; i++) push(v(0,0,0,0,1,0,0,0,0,0,2'b01,2'b00,2'b00), 1'b0, rand_op());
    push(v(1,1,0,0,1,0,0,0,0,0,2'b01,2'b00,2'b00), 1'b1, rand_op());
    push(v(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00), rand_bit(), o);
    case (o)
      LW: begin
        push(mem_addr, rand_bit(), o);
        for (int i = 0; i < mw; i++) push(v(0,0,0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00), 1'b0, rand_op());
        push(v(0,0,0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00), 1'b1, rand_op());
        push(v(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00), rand_bit(), rand_op());
      end
      SW: begin
        push(mem_addr, rand_bit(), o);
        for (int i = 0; i < mw; i++) push(v(0,0,0,1,0,1,0,0,0,0,2'b00,2'b00,2'b00), 1'b0, rand_op());
        push(v(0,0,0,1,0,1,0,0,0,0,2'b00,2'b00,2'b00), 1'b1, rand_op());
      end
      RTYPE: begin
        push(v(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00), rand_bit(), rand_op());
        push(v(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00), rand_bit(), rand_op());
      end
      BEQ:  push(v(0,0,1,0,0,0,0,0,0,1,2'b00,2'b01,2'b01), rand_bit(), rand_op());
      J:    push(v(0,1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10), rand_bit(), rand_op());
      ADDI: begin
        push(mem_addr, rand_bit(), rand_op());
        push(v(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00), rand_bit(), rand_op());
      end
      default: ;
    endcase
  endtask

  // Driver: entered #1 after a posedge; drives one cycle, checks at negedge.
  task automatic run_n(input int n);
    logic [15:0] e;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      mem_ready = mr_q.pop_front();
      op = op_q.pop_front();
      @(negedge clk);
      check("ctrl", 32'(outs()), 32'(e));
      check("rd_wr_excl", 32'(MemRead & MemWrite), 32'd0);
      check("rw_wr_excl", 32'(RegWrite & MemWrite), 32'd0);
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
      check("illegal_op", 32'(illegal_op), 32'd0);
`endif
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_all();
    run_n(exp_q.size());
  endtask

  // Reset, then release so the DUT sits in IDLE for one cycle before FETCH.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    #1;
    check("rst_outs", 32'(outs()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs", 32'(outs()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [5:0] ops[7];

  initial begin
    rst = 1'b1;
    op = '0;
    mem_ready = 1'b0;
    ops[0] = RTYPE; ops[1] = LW; ops[2] = SW; ops[3] = BEQ;
    ops[4] = J; ops[5] = ADDI; ops[6] = 6'b111111;
    #2;
    check("reset_state", 32'(outs()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_rst", 32'(outs()), 32'd0);
    @(posedge clk);
    #1;

    // Directed: each legal opcode with no waits, then LW with 2 MEMRD waits.
    add_instr(RTYPE, 0, 0);
    add_instr(LW, 0, 0);
    add_instr(SW, 0, 0);
    add_instr(BEQ, 0, 0);
    add_instr(J, 0, 0);
    add_instr(ADDI, 0, 0);
    add_instr(LW, 0, 2);
    add_instr(SW, 1, 3);
`ifndef MULTI_CYCLE_CTRL_TRAP_EN
    add_instr(6'b111111, 0, 0);
`endif
    run_all();

    // Reset mid-instruction while in EXEC.
    add_instr(RTYPE, 0, 0);
    run_n(2);
    check("in_exec", 32'(outs()), 32'(v(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00)));
    exp_q.delete();
    mr_q.delete();
    op_q.delete();
    do_reset();

    // Randomized stream.
    for (int k = 0; k < 60; k++) begin
      logic [5:0] o;
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
      o = ops[$urandom_range(0, 5)];
`else
      o = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(16, 31)) : ops[$urandom_range(0, 6)];
`endif
      add_instr(o, ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3),
                   ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3));
      run_all();
    end

`ifdef MULTI_CYCLE_CTRL_TRAP_EN
    // Unknown opcode parks in TRAP with all outputs low until reset.
    add_instr(6'b111111, 0, 0);
    run_all();
    for (int i = 0; i < 4; i++) begin
      mem_ready = rand_bit();
      op = rand_op();
      @(negedge clk);
      check("trap_outs", 32'(outs()), 32'd0);
      check("trap_flag", 32'(illegal_op), 32'd1);
      @(posedge clk);
      #1;
    end
    do_reset();
    add_instr(J, 0, 0);
    run_all();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
